// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, register-index width, NOP encoding.
// Also holds the load-use match function so the forwarding unit can reuse the same rule.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  // Encoding the IF/ID flush and ID/EX / EX/MEM bubble consumers load in place of an instruction.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic load_use_hit(
    input reg_t rs_id,
    input reg_t rt_id,
    input logic uses_rt_id,
    input logic mem_read_ex,
    input reg_t rt_ex
  );
    return mem_read_ex && (rt_ex != '0) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Pure wiring: no latency, no backpressure.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_t        rs_ID;
  reg_t        rt_ID;
  logic        uses_rt_ID;
  logic        MemRead_EX;
  reg_t        rt_EX;
  logic        branch_taken_EX;
  logic        muldiv_start_EX;

  logic        PC_write;
  logic        IF_ID_write;
  logic        IF_ID_flush;
  logic        ID_EX_write;
  logic        ID_EX_bubble;
  logic        EX_MEM_bubble;
  logic        muldiv_done;
  logic [31:0] perf_stall_cycles;

  modport master (
    output rs_ID, rt_ID, uses_rt_ID, MemRead_EX, rt_EX, branch_taken_EX, muldiv_start_EX,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble,
           muldiv_done, perf_stall_cycles
  );

  modport slave (
    input  rs_ID, rt_ID, uses_rt_ID, MemRead_EX, rt_EX, branch_taken_EX, muldiv_start_EX,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble,
           muldiv_done, perf_stall_cycles
  );

endinterface

// File: rtl/hazard_load_use_cmp.sv
// Combinational load-use detector: flags an ID source matching a non-zero load destination in EX.
// Zero latency, no backpressure.
module hazard_load_use_cmp
  import hazard_ctrl_pkg::*;
(
  input  reg_t rs_id,
  input  reg_t rt_id,
  input  logic uses_rt_id,
  input  logic mem_read_ex,
  input  reg_t rt_ex,
  output logic load_use
);

  assign load_use = load_use_hit(rs_id, rt_id, uses_rt_id, mem_read_ex, rt_ex);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, mult/div freeze of EX, stall-cycle counter.
// Controls are combinational in the hazard cycle; only state, cnt and the perf counter are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int               CNT_W    = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      perf_q;

  logic load_use;
  logic freeze;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_bubble;
  logic ex_mem_bubble;
  logic muldiv_done;

  hazard_load_use_cmp u_load_use_cmp (
    .rs_id       (hz.rs_ID),
    .rt_id       (hz.rt_ID),
    .uses_rt_id  (hz.uses_rt_ID),
    .mem_read_ex (hz.MemRead_EX),
    .rt_ex       (hz.rt_EX),
    .load_use    (load_use)
  );

  always_comb begin
    freeze        = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    muldiv_done   = 1'b0;

    if (!rst) begin
      case (state)
        RUN: begin
          // Priority only matters on a protocol violation; the EX events are exclusive.
          if (hz.muldiv_start_EX) begin
            freeze = 1'b1;
          end else if (hz.branch_taken_EX) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt > CNT_ONE) freeze = 1'b1;
          else               muldiv_done = 1'b1;
        end
        default: ;
      endcase
    end

    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      perf_q <= '0;
    end else begin
      if (!pc_write && (perf_q != 32'hFFFF_FFFF)) perf_q <= perf_q + 32'd1;

      case (state)
        RUN: begin
          if (hz.muldiv_start_EX) begin
            cnt   <= CNT_LOAD;
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          // muldiv_start_EX is still high here; only the count decides when to leave.
          if (cnt > CNT_ONE) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt   <= '0;
            state <= RUN;
          end
        end
        default: begin
          cnt   <= '0;
          state <= RUN;
        end
      endcase
    end
  end

  assign hz.PC_write          = pc_write;
  assign hz.IF_ID_write       = if_id_write;
  assign hz.IF_ID_flush       = if_id_flush;
  assign hz.ID_EX_write       = id_ex_write;
  assign hz.ID_EX_bubble      = id_ex_bubble;
  assign hz.EX_MEM_bubble     = ex_mem_bubble;
  assign hz.muldiv_done       = muldiv_done;
  assign hz.perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazards, hand sequences for mult/div, reset, saturation.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // Control word order: PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble, muldiv_done
  localparam logic [6:0] C_DEF    = 7'b1101000;
  localparam logic [6:0] C_STALL  = 7'b0001100;
  localparam logic [6:0] C_BRANCH = 7'b1111100;
  localparam logic [6:0] C_FREEZE = 7'b0000010;
  localparam logic [6:0] C_DONE   = 7'b1101001;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_rd;
    logic [4:0] rt_ex;
    logic       br;
    logic [6:0] exp_ctrl;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_perf;

  always #5 clk = ~clk;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

  hazard_ctrl #(.MULDIV_CYCLES(4)) dut_a (.clk(clk), .rst(rst_a), .hz(ifa.slave));
  hazard_ctrl #(.MULDIV_CYCLES(2)) dut_b (.clk(clk), .rst(rst_b), .hz(ifb.slave));

  function automatic logic [6:0] ctrl_a();
    return {ifa.PC_write, ifa.IF_ID_write, ifa.IF_ID_flush, ifa.ID_EX_write,
            ifa.ID_EX_bubble, ifa.EX_MEM_bubble, ifa.muldiv_done};
  endfunction

  function automatic logic [6:0] ctrl_b();
    return {ifb.PC_write, ifb.IF_ID_write, ifb.IF_ID_flush, ifb.ID_EX_write,
            ifb.ID_EX_bubble, ifb.EX_MEM_bubble, ifb.muldiv_done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mem_rd, input logic [4:0] rt_ex, input logic br,
                         input logic md);
    ifa.rs_ID           = rs;
    ifa.rt_ID           = rt;
    ifa.uses_rt_ID      = uses_rt;
    ifa.MemRead_EX      = mem_rd;
    ifa.rt_EX           = rt_ex;
    ifa.branch_taken_EX = br;
    ifa.muldiv_start_EX = md;
  endtask

  vec_t vec [8];

  initial begin
    vec[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, C_DEF};     // idle
    vec[1] = '{5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, C_STALL};   // load-use on rs
    vec[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, C_DEF};     // r0 never stalls
    vec[3] = '{5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, C_DEF};     // rt match, rt not read
    vec[4] = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, C_STALL};   // rt match, rt read
    vec[5] = '{5'd8, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, C_BRANCH};  // taken branch
    vec[6] = '{5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, C_DEF};     // match but not a load
    vec[7] = '{5'd7, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0, C_DEF};     // load, no match

    ifb.rs_ID = '0; ifb.rt_ID = '0; ifb.uses_rt_ID = 1'b0; ifb.MemRead_EX = 1'b0;
    ifb.rt_EX = '0; ifb.branch_taken_EX = 1'b0; ifb.muldiv_start_EX = 1'b0;

    // Reset: a live load-use must not leak through while rst is high.
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    #1 chk("reset_ctrl", 32'(ctrl_a()), 32'(C_DEF));
    @(posedge clk); #1;
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("reset_perf", ifa.perf_stall_cycles, 32'd0);
    chk("reset_perf_b", ifb.perf_stall_cycles, 32'd0);
    exp_perf = 32'd0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_a(vec[i].rs, vec[i].rt, vec[i].uses_rt, vec[i].mem_rd, vec[i].rt_ex, vec[i].br, 1'b0);
      #1 chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_a()), 32'(vec[i].exp_ctrl));
      if (!vec[i].exp_ctrl[6]) exp_perf = exp_perf + 32'd1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_perf", i), ifa.perf_stall_cycles, exp_perf);
    end

    // Mult/div, 4 cycles; a concurrent load-use is overridden and then ignored in MD_BUSY.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      drive_a(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1);
      #1 chk($sformatf("md4_c%0d", c), 32'(ctrl_a()), 32'(c < 4 ? C_FREEZE : C_DONE));
    end
    @(posedge clk); #1;
    chk("md4_perf", ifa.perf_stall_cycles, exp_perf + 32'd3);
    // First RUN cycle after done evaluates the pending load-use normally.
    @(negedge clk);
    drive_a(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    #1 chk("md4_after_load", 32'(ctrl_a()), 32'(C_STALL));
    @(posedge clk); #1;
    chk("md4_after_perf", ifa.perf_stall_cycles, exp_perf + 32'd4);
    @(negedge clk);
    drive_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 chk("md4_idle", 32'(ctrl_a()), 32'(C_DEF));

    // Mult/div on the 2-cycle instance: one freeze then done.
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      ifb.muldiv_start_EX = 1'b1;
      #1 chk($sformatf("md2_c%0d", c), 32'(ctrl_b()), 32'(c < 2 ? C_FREEZE : C_DONE));
    end
    @(negedge clk);
    ifb.muldiv_start_EX = 1'b0;
    #1 chk("md2_idle", 32'(ctrl_b()), 32'(C_DEF));
    chk("md2_perf", ifb.perf_stall_cycles, 32'd1);

    // Reset in the second MD_BUSY cycle aborts without a done pulse.
    @(negedge clk);
    drive_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 chk("mdrst_c1", 32'(ctrl_a()), 32'(C_FREEZE));
    @(negedge clk);
    #1 chk("mdrst_c2", 32'(ctrl_a()), 32'(C_FREEZE));
    @(negedge clk);
    rst_a = 1'b1;
    #1 chk("mdrst_in_reset", 32'(ctrl_a()), 32'(C_DEF));
    @(negedge clk);
    rst_a = 1'b0;
    ifa.muldiv_start_EX = 1'b0;
    #1 chk("mdrst_no_done", 32'(ctrl_a()), 32'(C_DEF));
    chk("mdrst_perf", ifa.perf_stall_cycles, 32'd0);
    @(negedge clk);
    #1 chk("mdrst_run", 32'(ctrl_a()), 32'(C_DEF));

    // Saturation: preload near the top, then keep stalling.
    @(negedge clk);
    force dut_a.perf_q = 32'hFFFF_FFFD;
    #1 release dut_a.perf_q;
    chk("sat_preload", ifa.perf_stall_cycles, 32'hFFFF_FFFD);
    drive_a(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_c%0d", c), ifa.perf_stall_cycles,
          (c == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
    @(negedge clk);
    drive_a(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
